// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes, FSM state types and latency width
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int LAT_W = 4;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
endpackage

// File: rtl/axi_lite_sram_slave_lat_lfsr.sv
// lat_lfsr: free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used as a latency source
module lat_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);
  logic [7:0] r_lfsr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_lfsr <= SEED;
    else r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign lfsr = r_lfsr;
endmodule

// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI4-Lite slave over a byte-writable word SRAM with fixed or
// pseudo-random response latency; read and write channels run independently.
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter int MEM_WORDS = 4096,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 2,
  parameter bit RAND_LAT = 1'b0,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int IW = $clog2(MEM_WORDS);
  logic [31:0] r_mem [MEM_WORDS];
  logic [7:0] w_lfsr;
  lat_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .lfsr(w_lfsr));
  logic [LAT_W-1:0] w_rd_lat, w_wr_lat;
  assign w_rd_lat = RAND_LAT ? LAT_W'(w_lfsr) : LAT_W'(RD_LATENCY);
  assign w_wr_lat = RAND_LAT ? LAT_W'(w_lfsr) : LAT_W'(WR_LATENCY);
  rd_state_t r_rstate;
  logic [31:0] r_araddr, r_rdata;
  logic [LAT_W-1:0] r_rcnt;
  logic [1:0] r_rresp;
  logic r_arready, r_rvalid;
  logic [31:0] w_rd_addr, w_roff;
  logic [IW-1:0] w_rd_idx;
  logic w_rd_ok, w_ar_hs, w_rd_sample;
  // zero latency samples the SRAM on the AR handshake edge itself, using the live address
  assign w_rd_addr = r_rstate == R_IDLE ? araddr : r_araddr;
  assign w_roff = w_rd_addr - MEM_BASE;
  assign w_rd_ok = w_roff < 32'(4 * MEM_WORDS);
  assign w_rd_idx = w_roff[IW+1:2];
  assign w_ar_hs = arvalid & r_arready;
  assign w_rd_sample = (w_ar_hs & w_rd_lat == '0) | (r_rstate == R_WAIT & r_rcnt == '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
      r_araddr <= '0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
      r_rcnt <= '0;
      r_arready <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_rd_sample) begin
        r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
        r_rresp <= w_rd_ok ? RESP_OKAY : RESP_DECERR;
      end
      case (r_rstate)
        R_IDLE: begin
          r_arready <= ~w_ar_hs;
          if (w_ar_hs) begin
            r_araddr <= araddr;
            r_rcnt <= w_rd_lat;
            r_rvalid <= w_rd_lat == '0;
            r_rstate <= w_rd_lat == '0 ? R_RESP : R_WAIT;
          end
        end
        R_WAIT: begin
          r_rcnt <= r_rcnt - LAT_W'(1);
          if (r_rcnt == '0) begin
            r_rvalid <= 1'b1;
            r_rstate <= R_RESP;
          end
        end
        R_RESP:
          if (rready) begin
            r_rvalid <= 1'b0;
            r_arready <= 1'b1;
            r_rstate <= R_IDLE;
          end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end
  wr_state_t r_wstate;
  logic [31:0] r_awaddr, r_wdata;
  logic [3:0] r_wstrb;
  logic [LAT_W-1:0] r_wcnt;
  logic [1:0] r_bresp;
  logic r_aw_held, r_w_held, r_awready, r_wready, r_bvalid;
  logic [31:0] w_wr_addr, w_wr_data, w_woff;
  logic [3:0] w_wr_strb;
  logic [IW-1:0] w_wr_idx;
  logic w_aw_hs, w_w_hs, w_aw_n, w_w_n, w_both, w_wr_ok, w_commit;
  assign w_aw_hs = awvalid & r_awready;
  assign w_w_hs = wvalid & r_wready;
  assign w_aw_n = r_aw_held | w_aw_hs;
  assign w_w_n = r_w_held | w_w_hs;
  assign w_both = r_wstate == W_IDLE & w_aw_n & w_w_n;
  // a half captured on this very edge is not in its register yet, so take it from the bus
  assign w_wr_addr = r_aw_held ? r_awaddr : awaddr;
  assign w_wr_data = r_w_held ? r_wdata : wdata;
  assign w_wr_strb = r_w_held ? r_wstrb : wstrb;
  assign w_woff = w_wr_addr - MEM_BASE;
  assign w_wr_ok = w_woff < 32'(4 * MEM_WORDS);
  assign w_wr_idx = w_woff[IW+1:2];
  assign w_commit = (w_both & w_wr_lat == '0) | (r_wstate == W_WAIT & r_wcnt == '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_awaddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_wcnt <= '0;
      r_bresp <= RESP_OKAY;
      r_aw_held <= 1'b0;
      r_w_held <= 1'b0;
      r_awready <= 1'b0;
      r_wready <= 1'b0;
      r_bvalid <= 1'b0;
    end else begin
      if (w_commit) r_bresp <= w_wr_ok ? RESP_OKAY : RESP_DECERR;
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) r_awaddr <= awaddr;
          if (w_w_hs) begin
            r_wdata <= wdata;
            r_wstrb <= wstrb;
          end
          r_aw_held <= w_aw_n;
          r_w_held <= w_w_n;
          r_awready <= ~w_aw_n;
          r_wready <= ~w_w_n;
          if (w_both) begin
            r_wcnt <= w_wr_lat;
            r_bvalid <= w_wr_lat == '0;
            r_wstate <= w_wr_lat == '0 ? W_RESP : W_WAIT;
          end
        end
        W_WAIT: begin
          r_wcnt <= r_wcnt - LAT_W'(1);
          if (r_wcnt == '0) begin
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP:
          if (bready) begin
            r_bvalid <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held <= 1'b0;
            r_awready <= 1'b1;
            r_wready <= 1'b1;
            r_wstate <= W_IDLE;
          end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end
  // contents survive reset, so the array has no reset branch
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (w_commit && w_wr_ok && w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
  assign arready = r_arready;
  assign rdata = r_rdata;
  assign rresp = r_rresp;
  assign rvalid = r_rvalid;
  assign awready = r_awready;
  assign wready = r_wready;
  assign bresp = r_bresp;
  assign bvalid = r_bvalid;
endmodule
